// File: rtl/config_loader.sv
// config_loader: streams a header, address/data pairs and an optional trailer
// from a valid/ready word interface and issues single-cycle writes on the
// fabric configuration bus.
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN adds a CHECK state that
// compares a trailer word against the XOR of every accepted ADDR and DATA word.
module config_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] write_count
);

  localparam logic [15:0] HDR_MAGIC    = 16'hC0F1;
  localparam logic [15:0] RSV_SECTION  = 16'hFFFF;
  localparam logic [31:0] IDLE_ADDR    = 32'hFFFF_FFFF;
  localparam logic [31:0] IDLE_DATA    = 32'h0000_0000;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;
  // After the last write (or an empty header) the trailer must be checked.
  localparam state_t S_FINISH = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;
  // Without a trailer the session is complete right after the last write.
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_count;
  logic [15:0] r_write_count;
  logic [31:0] r_addr;
  logic [31:0] r_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [31:0] r_csum;
`endif

  logic w_accept;
  logic w_start_ok;
  logic w_last_write;
  logic w_hdr_ok;
  logic w_addr_rsv;

  // A transfer happens only when the loader is ready and upstream is valid.
  assign w_accept     = in_valid && in_ready;
  // Start is honoured only between sessions; mid-session pulses are dropped.
  assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERR));
  // count >= 1 whenever WRITE is reached, so write_count + 1 never wraps here.
  assign w_last_write = ((r_write_count + 16'd1) == r_count);
  assign w_hdr_ok     = (in_data[31:16] == HDR_MAGIC);
  assign w_addr_rsv   = (in_data[31:16] == RSV_SECTION);

  // State register: reset always wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; accepting states hold while in_valid is low.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start_ok) begin
          w_state_next = S_HDR;
        end
      end
      S_HDR: begin
        if (w_accept) begin
          if (!w_hdr_ok) begin
            w_state_next = S_ERR;
          end else if (in_data[15:0] == 16'd0) begin
            w_state_next = S_FINISH;
          end else begin
            w_state_next = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (w_accept) begin
          w_state_next = w_addr_rsv ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_next = w_last_write ? S_FINISH : S_ADDR;
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_accept) begin
          w_state_next = (in_data == r_csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Session datapath: header count, pending pair, write counter, checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= 16'd0;
      r_write_count <= 16'd0;
      r_addr        <= 32'd0;
      r_data        <= 32'd0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      r_csum        <= 32'd0;
`endif
    end else begin
      if (w_start_ok) begin
        r_write_count <= 16'd0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        r_csum        <= 32'd0;
`endif
      end
      if ((r_state == S_HDR) && w_accept && w_hdr_ok) begin
        r_count <= in_data[15:0];
      end
      if ((r_state == S_ADDR) && w_accept) begin
        r_addr <= in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ in_data;
`endif
      end
      if ((r_state == S_DATA) && w_accept) begin
        r_data <= in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ in_data;
`endif
      end
      if (r_state == S_WRITE) begin
        r_write_count <= r_write_count + 16'd1;
      end
    end
  end

  // Outputs decoded purely from state so the bus is idle outside WRITE.
  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    config_addr = IDLE_ADDR;
    config_data = IDLE_DATA;
    case (r_state)
      S_HDR, S_ADDR, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_WRITE: begin
        busy        = 1'b1;
        config_addr = r_addr;
        config_data = r_data;
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign write_count = r_write_count;

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader: randomized sessions checked against a
// session-level reference model (word list in, expected writes/status out).
// Honours CONFIG_LOADER_CHECKSUM_EN the same way as the design.
module tb_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] write_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [63:0] got_w[$];
  int          got_cyc[$];
  int          idle_bad;

  logic [31:0] stim[$];
  logic [63:0] exp_w[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_used;
  int          acc_cyc[$];

  config_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .config_addr (config_addr),
    .config_data (config_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: every non-idle cycle is one write beat.
  always @(negedge clk) begin
    if (config_addr !== 32'hFFFF_FFFF) begin
      got_w.push_back({config_addr, config_data});
      got_cyc.push_back(cyc);
    end else if (config_data !== 32'd0) begin
      idle_bad++;
    end
  end

  // Reference model: walk the word list by the protocol rules.
  task automatic model();
    logic [31:0] w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] cs;
    int n;
    int p;
    exp_w.delete();
    exp_done = 0;
    exp_err  = 0;
    p  = 0;
    cs = 0;
    w  = stim[p];
    p++;
    if (w[31:16] != 16'hC0F1) begin
      exp_err = 1;
    end else begin
      n = int'(w[15:0]);
      for (int k = 0; k < n; k++) begin
        a = stim[p];
        p++;
        if (a[31:16] == 16'hFFFF) begin
          exp_err = 1;
          break;
        end
        d = stim[p];
        p++;
        exp_w.push_back({a, d});
        cs = cs ^ a ^ d;
      end
      if (!exp_err) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
        w = stim[p];
        p++;
        if (w == cs) exp_done = 1;
        else exp_err = 1;
`else
        exp_done = 1;
`endif
      end
    end
    exp_used = p;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:16] == 16'hFFFF) a[31:16] = 16'h0001;
    return a;
  endfunction

  // Appends a trailer (checksum build only); bad=1 corrupts it.
  task automatic add_trailer(input bit bad);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] cs;
    cs = 0;
    for (int i = 1; i < stim.size(); i++) cs = cs ^ stim[i];
    if (bad) cs = cs ^ (32'd1 << $urandom_range(31, 0));
    stim.push_back(cs);
`else
    if (bad) stim.push_back(32'd0);
`endif
  endtask

  task automatic build(input int n, input bit bad_trailer);
    stim.delete();
    stim.push_back({16'hC0F1, n[15:0]});
    for (int i = 0; i < n; i++) begin
      stim.push_back(rand_addr());
      stim.push_back($urandom);
    end
    add_trailer(bad_trailer);
  endtask

  task automatic clear_mon();
    got_w.delete();
    got_cyc.delete();
    acc_cyc.delete();
    idle_bad = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      ok = 0;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc_cyc.push_back(cyc);
    in_valid = 1'b0;
    in_data  = $urandom;
    repeat (gap) @(negedge clk);
    ok = 1;
  endtask

  task automatic feed(input string name, input int from, input int gmin, input int gmax);
    bit ok;
    for (int i = from; i < exp_used; i++) begin
      send_word(stim[i], $urandom_range(gmax, gmin), ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL %s: in_ready timeout at word %0d got 0 expected 1", name, i);
        return;
      end
    end
  endtask

  task automatic check_session(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (got_w.size() !== exp_w.size()) begin
      errors++;
      $display("FAIL %s nwrites: got %0d expected %0d", name, got_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size(); i++) begin
      checks++;
      if (i >= got_w.size() || got_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s write%0d: got %h expected %h", name, i,
                 (i < got_w.size()) ? got_w[i] : 64'hX, exp_w[i]);
      end
    end
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, done, exp_done);
    end
    checks++;
    if (error !== exp_err) begin
      errors++;
      $display("FAIL %s error: got %b expected %b", name, error, exp_err);
    end
    checks++;
    if (write_count !== 16'(exp_w.size())) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, write_count, exp_w.size());
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s busy/in_ready: got %b/%b expected 0/0", name, busy, in_ready);
    end
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL %s idle_data: got %0d nonzero idle cycles expected 0", name, idle_bad);
    end
    $display("session %s: writes=%0d done=%b error=%b write_count=%0d",
             name, got_w.size(), done, error, write_count);
  endtask

  task automatic run_session(input string name, input int gmin, input int gmax);
    model();
    clear_mon();
    do_start();
    feed(name, 0, gmin, gmax);
    check_session(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    in_valid = 1'b0;
    in_data = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (config_addr !== 32'hFFFF_FFFF || config_data !== 32'd0) begin
      errors++;
      $display("FAIL reset bus: got %h/%h expected ffffffff/00000000", config_addr, config_data);
    end
    checks++;
    if ({in_ready, busy, done, error} !== 4'b0000 || write_count !== 16'd0) begin
      errors++;
      $display("FAIL reset status: got rdy=%b busy=%b done=%b err=%b wc=%0d expected all 0",
               in_ready, busy, done, error, write_count);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start busy: got %b expected 0", busy);
    end
    $display("reset: bus=%h busy=%b", config_addr, busy);
  endtask

  task automatic test_basic();
    stim.delete();
    stim.push_back(32'hC0F1_0001);
    stim.push_back(32'h0007_0003);
    stim.push_back(32'h0000_0005);
    add_trailer(0);
    run_session("basic", 0, 0);
  endtask

  task automatic test_gapped();
    build(2, 0);
    run_session("gapped", 2, 2);
    checks++;
    if (got_cyc.size() == 2 && (got_cyc[1] - got_cyc[0]) <= 1) begin
      errors++;
      $display("FAIL gapped separation: got %0d cycles expected >1", got_cyc[1] - got_cyc[0]);
    end
  endtask

  task automatic test_bad_magic();
    stim.delete();
    stim.push_back(32'h1234_0001);
    run_session("bad_magic", 0, 0);
    in_valid = 1'b1;
    in_data = 32'h0007_0003;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || error !== 1'b1 || got_w.size() !== 0) begin
      errors++;
      $display("FAIL bad_magic hold: got rdy=%b err=%b writes=%0d expected 0/1/0",
               in_ready, error, got_w.size());
    end
  endtask

  task automatic test_reserved();
    build(2, 0);
    stim[3] = {16'hFFFF, stim[3][15:0]};
    run_session("reserved", 0, 1);
  endtask

  task automatic test_zero_count();
    build(0, 0);
    run_session("zero_count", 0, 0);
  endtask

  task automatic test_back_to_back();
    build(4, 0);
    run_session("back_to_back", 0, 0);
    for (int k = 1; k < got_cyc.size(); k++) begin
      checks++;
      if (got_cyc[k] - got_cyc[k-1] !== 3) begin
        errors++;
        $display("FAIL b2b spacing%0d: got %0d expected 3", k, got_cyc[k] - got_cyc[k-1]);
      end
    end
    for (int k = 0; k < got_cyc.size() && (2 + 2*k) < acc_cyc.size(); k++) begin
      checks++;
      if (got_cyc[k] !== acc_cyc[2 + 2*k]) begin
        errors++;
        $display("FAIL b2b latency%0d: got cycle %0d expected %0d", k, got_cyc[k], acc_cyc[2 + 2*k]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    build(3, 0);
    clear_mon();
    do_start();
    for (int i = 0; i < 3; i++) begin
      send_word(stim[i], 0, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL mid_write: in_ready timeout got 0 expected 1");
        return;
      end
    end
    checks++;
    if (config_addr !== stim[1] || config_data !== stim[2]) begin
      errors++;
      $display("FAIL mid_write drive: got %h/%h expected %h/%h", config_addr, config_data, stim[1], stim[2]);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (config_addr !== 32'hFFFF_FFFF || busy !== 1'b0 || write_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_write reset: got addr=%h busy=%b wc=%0d expected ffffffff/0/0",
               config_addr, busy, write_count);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (got_w.size() !== 1) begin
      errors++;
      $display("FAIL mid_write retry: got %0d writes expected 1", got_w.size());
    end
    $display("session mid_write_reset: writes=%0d busy=%b", got_w.size(), busy);
  endtask

  task automatic test_start_ignored();
    bit ok;
    build(2, 0);
    model();
    clear_mon();
    do_start();
    send_word(stim[0], 0, ok);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed("start_ignored", 1, 0, 1);
    check_session("start_ignored");
  endtask

  task automatic test_random();
    for (int s = 0; s < 10; s++) begin
      build($urandom_range(5, 1), ($urandom_range(1, 0) == 1));
      if ($urandom_range(9, 0) == 0) stim[0] = {16'h5A5A, stim[0][15:0]};
      if ($urandom_range(7, 0) == 0) stim[1] = {16'hFFFF, stim[1][15:0]};
      run_session($sformatf("random%0d", s), 0, 3);
    end
  endtask

`ifdef CONFIG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim.delete();
    stim.push_back(32'hC0F1_0001);
    stim.push_back(32'h0004_0002);
    stim.push_back(32'h0000_0003);
    stim.push_back(32'h0004_0001);
    run_session("csum_good", 0, 0);
    stim[3] = 32'd0;
    run_session("csum_bad", 0, 0);
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gapped();
    test_bad_magic();
    test_reserved();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_write();
    test_start_ignored();
`ifdef CONFIG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle pulse that begins a load session.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  32  upstream bitstream word.
REQ-006 in_ready  output  1  loader accepts in_data this cycle; transfer when in_valid && in_ready.
REQ-007 config_addr  output  32  fabric config address: [31:16] block section, [15:0] tile_id.
REQ-008 config_data  output  32  fabric config payload.
REQ-009 busy  output  1  session in progress (HDR through CHECK).
REQ-010 done  output  1  sticky: session completed without error.
REQ-011 error  output  1  sticky: session aborted or checksum mismatch.
REQ-012 write_count  output  16  number of config writes issued in the current session.

Function
REQ-013 Idle bus value SHALL be config_addr = 32'hFFFF_FFFF, config_data = 0; section 16'hFFFF is reserved and decodes to no block.
REQ-014 States SHALL be IDLE, HDR, ADDR, DATA, WRITE, CHECK, DONE, ERR.
REQ-015 in_ready SHALL be 1 only in HDR, ADDR, DATA, CHECK; 0 elsewhere.
REQ-016 IDLE/DONE/ERR: start SHALL clear done, error, write_count and enter HDR; start in any other state SHALL be ignored.
REQ-017 HDR: accepted word with [31:16] == 16'hC0F1 SHALL latch count = [15:0]; count 0 -> CHECK (macro on) or DONE; count != 0 -> ADDR; wrong magic -> ERR.
REQ-018 ADDR: accepted word SHALL be latched as the pending address; word with [31:16] == 16'hFFFF -> ERR (reserved section); else -> DATA.
REQ-019 DATA: accepted word SHALL be latched as the pending data; -> WRITE.
REQ-020 WRITE SHALL last exactly one cycle, driving the pending addr/data on config_addr/config_data for that cycle only; write_count increments on exit.
REQ-021 Config bus SHALL return to the idle value in every cycle outside WRITE; latency from accepted DATA word to bus drive is exactly 1 cycle.
REQ-022 Exit WRITE: if write_count+1 == count -> CHECK (macro on) or DONE; else -> ADDR.
REQ-023 Back-to-back pairs with in_valid held high SHALL sustain one write per 3 cycles.
REQ-024 in_valid low in any accepting state SHALL stall with no state change.
REQ-025 busy = 1 in HDR, ADDR, DATA, WRITE, CHECK; done = 1 only in DONE; error = 1 only in ERR.
REQ-026 count and write_count SHALL be 16-bit unsigned; 65535 pairs is the maximum session; no wrap within a session.

Reset
REQ-027 reset SHALL force IDLE, config_addr = 32'hFFFF_FFFF, config_data = 0, in_ready = busy = done = error = 0, write_count = 0, checksum accumulator = 0.
REQ-028 reset mid-WRITE SHALL take priority: bus reads idle in the next cycle; no partial write is retried.
REQ-029 reset and start asserted together SHALL resolve to IDLE (reset wins).

Configuration
REQ-030 Macro CONFIG_LOADER_CHECKSUM_EN defined: the loader SHALL XOR every accepted ADDR and DATA word into a 32-bit accumulator (cleared by start); CHECK accepts one trailer word, equal -> DONE, unequal -> ERR; writes already issued are not undone.
REQ-031 Macro undefined: CHECK state, accumulator and trailer word SHALL be absent; sessions end in DONE directly after the last write or after a zero-count header.

Verification
REQ-032 reset; start; words C0F1_0001, 0007_0003, 0000_0005 -> one-cycle config_addr = 0007_0003, config_data = 5, write_count = 1, done = 1 (macro off).
REQ-033 start; header C0F1_0002, two pairs with in_valid gapped 2 cycles between words -> exactly two single-cycle writes in order, bus idle between, done = 1.
REQ-034 start; header 1234_0001 -> error = 1, no write issued, in_ready = 0 until next start.
REQ-035 macro on: C0F1_0001, 0004_0002, 0000_0003, trailer 0004_0001 -> write issued then done = 1; trailer 0 -> error = 1 with write_count = 1.
REQ-036 start; header C0F1_0003; reset asserted during first WRITE -> next cycle config_addr = FFFF_FFFF, busy = 0, write_count = 0.
REQ-037 start during ADDR of active session -> ignored; session completes normally with correct write_count.
